// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: round-robin PCI bus arbiter. Grants move only between transactions and idle grants time out.
// Optional ARB_PARK_EN parks the bus on PARK_ID while nobody requests.
module pci_rr_arbiter #(
  parameter int N_MASTERS = 3,
  parameter int TIMEOUT = 16,
  parameter int PARK_ID = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_vld
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;
  state_t state, stateNxt, idleSt;
  logic [IW-1:0] gId, gIdNxt, rrPtr, rrNxt, ownerNxt, winner, gntIdx;
  logic [TW-1:0] tmoCnt, tmoNxt;
  logic [N_MASTERS-1:0] reqs, gMask;
  logic busIdle, prevIdle, anyReq, ownReq, otherReq, vldNxt, gntOn;
  assign busIdle = frame_n & irdy_n;
  assign reqs = ~req_n;
  assign gMask = {{(N_MASTERS-1){1'b0}}, 1'b1} << gId;
  assign anyReq = |reqs;
  assign ownReq = |(reqs & gMask);
  assign otherReq = |(reqs & ~gMask);
`ifdef ARB_PARK_EN
  // leaving a non-park master must still pass through a gap before parking
  assign idleSt = (gId == IW'(PARK_ID)) ? IDLE : GAP;
`else
  assign idleSt = IDLE;
`endif
  always_comb begin
    winner = rrPtr;
    for (int i = N_MASTERS; i >= 1; i--)
      if (reqs[IW'((int'(rrPtr) + i) % N_MASTERS)]) winner = IW'((int'(rrPtr) + i) % N_MASTERS);
  end
  always_comb begin
    stateNxt = state;
    gIdNxt = gId;
    rrNxt = rrPtr;
    ownerNxt = owner;
    vldNxt = owner_vld;
    tmoNxt = tmoCnt;
    case (state)
      IDLE: begin
`ifdef ARB_PARK_EN
        if (!frame_n && prevIdle) begin
          stateNxt = BUSY;
          gIdNxt = IW'(PARK_ID);
          ownerNxt = IW'(PARK_ID);
          rrNxt = IW'(PARK_ID);
          vldNxt = 1'b1;
          tmoNxt = '0;
        end else if (anyReq) begin
          stateNxt = (winner == IW'(PARK_ID)) ? GRANT : GAP;
          gIdNxt = winner;
          tmoNxt = '0;
        end
`else
        if (anyReq) begin
          stateNxt = GRANT;
          gIdNxt = winner;
          tmoNxt = '0;
        end
`endif
      end
      GRANT: begin
        if (!frame_n && prevIdle) begin
          stateNxt = BUSY;
          ownerNxt = gId;
          rrNxt = gId;
          vldNxt = 1'b1;
          tmoNxt = '0;
        end else if (!ownReq && frame_n) begin
          stateNxt = otherReq ? GAP : idleSt;
        end else if (tmoCnt == TW'(TIMEOUT - 1)) begin
          stateNxt = GAP;
          rrNxt = gId;
        end else if (busIdle) begin
          tmoNxt = tmoCnt + TW'(1);
        end
      end
      BUSY: begin
        if (busIdle) begin
          vldNxt = 1'b0;
          tmoNxt = '0;
          stateNxt = !anyReq ? idleSt : (winner == gId) ? GRANT : GAP;
        end
      end
      default: begin
        stateNxt = anyReq ? GRANT : IDLE;
        gIdNxt = winner;
        tmoNxt = '0;
      end
    endcase
  end
  always_comb begin
    gntOn = (stateNxt == GRANT) || (stateNxt == BUSY);
    gntIdx = gIdNxt;
`ifdef ARB_PARK_EN
    if (stateNxt == IDLE) begin
      gntOn = 1'b1;
      gntIdx = IW'(PARK_ID);
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gId <= '0;
      rrPtr <= IW'(N_MASTERS - 1);
      tmoCnt <= '0;
      prevIdle <= 1'b1;
      gnt_n <= '1;
      owner <= '0;
      owner_vld <= 1'b0;
    end else begin
      state <= stateNxt;
      gId <= gIdNxt;
      rrPtr <= rrNxt;
      tmoCnt <= tmoNxt;
      prevIdle <= busIdle;
      gnt_n <= gntOn ? ~({{(N_MASTERS-1){1'b0}}, 1'b1} << gntIdx) : '1;
      owner <= ownerNxt;
      owner_vld <= vldNxt;
    end
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// tb_pci_rr_arbiter: directed PCI arbitration scenarios plus randomized bus traffic against a transaction-level model.
// Targets the default (unparked) build.
module tb_pci_rr_arbiter;
  localparam int N = 3;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_n = '1;
  logic frame_n = 1'b1;
  logic irdy_n = 1'b1;
  logic [N-1:0] gnt_n;
  logic [1:0] owner;
  logic owner_vld;
  int nCmp = 0;
  int nBad = 0;
  int mHold, mOwner, mPtr, mWait;
  bit mTxn, mGap, mPrevIdle;

  pci_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO), .PARK_ID(0)) dut (
    .clk(clk), .rst(rst), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n), .owner(owner), .owner_vld(owner_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (!r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    mHold = -1; mOwner = 0; mPtr = N - 1; mWait = 0;
    mTxn = 0; mGap = 0; mPrevIdle = 1;
  endtask

  // holder -1 means nobody granted; a pending gap hands the bus to whoever wins one cycle later
  task automatic model_step(input logic [N-1:0] r, input logic f, input logic i);
    int w;
    bit idle, others;
    w = pick(r, mPtr);
    idle = f & i;
    others = 0;
    for (int j = 0; j < N; j++) if (j != mHold && !r[j]) others = 1;
    if (mGap) begin
      mGap = 0; mHold = w; mWait = 0;
    end else if (mHold < 0) begin
      if (w >= 0) begin mHold = w; mWait = 0; end
    end else if (mTxn) begin
      if (idle) begin
        mTxn = 0; mWait = 0;
        if (w < 0) mHold = -1;
        else if (w != mHold) begin mHold = -1; mGap = 1; end
      end
    end else if (!f && mPrevIdle) begin
      mTxn = 1; mOwner = mHold; mPtr = mHold; mWait = 0;
    end else if (r[mHold] && f) begin
      mGap = others; mHold = -1;
    end else if (mWait == TMO - 1) begin
      mPtr = mHold; mHold = -1; mGap = 1;
    end else if (idle) begin
      mWait++;
    end
    mPrevIdle = idle;
  endtask

  task automatic check();
    logic [N-1:0] expG;
    expG = '1;
    if (mHold >= 0) expG[mHold] = 1'b0;
    chk("gnt_n", {5'b0, gnt_n}, {5'b0, expG});
    chk("owner_vld", {7'b0, owner_vld}, {7'b0, mTxn});
    chk("owner", {6'b0, owner}, 8'(mOwner));
    chk("one_grant", {7'b0, ($countones(~gnt_n) <= 1)}, 8'd1);
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic f, input logic i);
    req_n = r; frame_n = f; irdy_n = i;
    model_step(r, f, i);
    @(negedge clk);
    check();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", {5'b0, gnt_n}, 8'h07);
    chk("rst_vld", {7'b0, owner_vld}, 8'h00);
    req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check();
  endtask

  initial begin
    logic [N-1:0] r;
    int fl, il;
    bit quiet;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check();
    cyc(3'b110, 1, 1);
    chk("t2_grant", {5'b0, gnt_n}, 8'h06);
    cyc(3'b110, 0, 0);
    chk("t2_owner", {6'b0, owner}, 8'd0);
    chk("t2_vld", {7'b0, owner_vld}, 8'd1);
    cyc(3'b110, 0, 0);
    do_reset();
    // all request: each transaction hands over through one gap cycle
    for (int k = 0; k < 4; k++) begin
      cyc(3'b000, 1, 1);
      chk("t3_grant", {5'b0, gnt_n}, {5'b0, ~(3'b001 << (k % N))});
      cyc(3'b000, 0, 0);
      cyc(3'b000, 0, 0);
      chk("t3_owner", {6'b0, owner}, 8'(k % N));
      cyc(3'b000, 1, 1);
      chk("t3_gap", {5'b0, gnt_n}, 8'h07);
    end
    do_reset();
    cyc(3'b110, 1, 1);
    cyc(3'b100, 0, 0);
    cyc(3'b100, 1, 0);
    cyc(3'b100, 1, 0);
    chk("t6_hold", {5'b0, gnt_n}, 8'h06);
    cyc(3'b100, 1, 1);
    chk("t6_gap", {5'b0, gnt_n}, 8'h07);
    cyc(3'b100, 1, 1);
    chk("t6_b", {5'b0, gnt_n}, 8'h05);
    do_reset();
    cyc(3'b101, 1, 1);
    chk("t4_b", {5'b0, gnt_n}, 8'h05);
    for (int k = 0; k < TMO - 1; k++) cyc(3'b001, 1, 1);
    chk("t4_still_b", {5'b0, gnt_n}, 8'h05);
    cyc(3'b001, 1, 1);
    chk("t4_timeout", {5'b0, gnt_n}, 8'h07);
    cyc(3'b001, 1, 1);
    chk("t4_c", {5'b0, gnt_n}, 8'h03);
    do_reset();
    // lone requester regains the bus without a gap; FRAME# beats a dropped request
    cyc(3'b110, 1, 1);
    cyc(3'b110, 0, 0);
    cyc(3'b110, 1, 1);
    chk("single_nogap", {5'b0, gnt_n}, 8'h06);
    cyc(3'b111, 0, 0);
    chk("frame_wins", {7'b0, owner_vld}, 8'd1);
    cyc(3'b111, 1, 1);
    chk("busy_to_idle", {5'b0, gnt_n}, 8'h07);
    cyc(3'b011, 0, 0);
    cyc(3'b011, 0, 0);
    chk("frozen_grant", {7'b0, owner_vld}, 8'd0);
    cyc(3'b011, 1, 1);
    cyc(3'b011, 0, 0);
    chk("late_busy", {6'b0, owner}, 8'd2);
    cyc(3'b011, 1, 1);
    do_reset();
    r = '1; fl = 0; il = 0; quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 80 == 0) quiet = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < N; j++)
        if ($urandom_range(0, quiet ? 40 : 4) == 0) r[j] = ~r[j];
      if (fl == 0 && il == 0 && mHold >= 0 && !quiet && $urandom_range(0, 2) == 0) begin
        fl = $urandom_range(1, 3);
        il = fl + $urandom_range(0, 2);
      end
      if (c == 1500) begin
        #1 rst = 1'b1;
        #1;
        chk("rnd_rst_gnt", {5'b0, gnt_n}, 8'h07);
        model_reset();
        fl = 0; il = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      cyc(r, !(fl > 0), !(il > 0));
      if (fl > 0) fl--;
      if (il > 0) il--;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
